// File: rtl/tx_window_ctrl_if.sv
// Control/status bundle between the flight-computer side and the transmit-window controller.
// The master drives the timebase and requests; the slave (controller) returns registered status.
interface tx_window_ctrl_if #(
  parameter int CNT_W  = 16,
  parameter int WCNT_W = 8
);
  logic              tick;
  logic              arm;
  logic              mode;
  logic              abort;
  logic              tx_enable;
  logic              guard_active;
  logic              done;
  logic              aborted;
  logic [CNT_W-1:0]  ticks_left;
  logic [WCNT_W-1:0] window_count;

  modport master (
    output tick, arm, mode, abort,
    input  tx_enable, guard_active, done, aborted, ticks_left, window_count
  );

  modport slave (
    input  tick, arm, mode, abort,
    output tx_enable, guard_active, done, aborted, ticks_left, window_count
  );
endinterface

// File: rtl/tx_window_ctrl.sv
// Transmit-window controller: opens a bounded window on request, closes it after a number of
// prescaled ticks or on abort, then holds off new windows for a guard interval.
module tx_window_ctrl #(
  parameter int CNT_W        = 16,
  parameter int WINDOW_TICKS = 4800,
  parameter int GUARD_TICKS  = 600,
  parameter int WCNT_W       = 8
) (
  input  logic            clk,
  input  logic            reset,
  tx_window_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GUARD  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0]  WIN_LOAD   = CNT_W'(WINDOW_TICKS);
  localparam logic [CNT_W-1:0]  GUARD_LOAD = CNT_W'(GUARD_TICKS);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [WCNT_W-1:0] WCNT_ONE   = WCNT_W'(1);
  localparam logic              HAS_GUARD  = (GUARD_TICKS != 32'sd0);

  state_t             state_r;
  state_t             state_s;
  logic [CNT_W-1:0]   win_cnt_r;
  logic [CNT_W-1:0]   win_cnt_s;
  logic [CNT_W-1:0]   guard_cnt_r;
  logic [CNT_W-1:0]   guard_cnt_s;
  logic [WCNT_W-1:0]  wcount_r;
  logic [WCNT_W-1:0]  wcount_s;
  logic               arm_q_r;
  logic               start_s;
  logic               close_s;
  logic               done_s;
  logic               aborted_s;
  logic               done_r;
  logic               aborted_r;
  logic               tx_enable_r;
  logic               guard_active_r;

  // Start request: level in gated mode, rising edge of arm in latched mode.
  always_comb begin
    start_s = 1'b0;
    if (bus.mode) begin
      start_s = bus.arm & ~arm_q_r;
    end else begin
      start_s = bus.arm;
    end
  end

  // Next-state, counter and strobe logic.
  always_comb begin
    state_s     = state_r;
    win_cnt_s   = win_cnt_r;
    guard_cnt_s = guard_cnt_r;
    wcount_s    = wcount_r;
    close_s     = 1'b0;
    done_s      = 1'b0;
    aborted_s   = 1'b0;
    case (state_r)
      IDLE: begin
        // A tick coinciding with the start is deliberately not counted against the window.
        if (start_s) begin
          state_s   = ACTIVE;
          win_cnt_s = WIN_LOAD;
          wcount_s  = wcount_r + WCNT_ONE;
        end else begin
          state_s = IDLE;
        end
      end
      ACTIVE: begin
        if (bus.abort || (!bus.mode && !bus.arm)) begin
          aborted_s = 1'b1;
          close_s   = 1'b1;
        end else if (bus.tick) begin
          if (win_cnt_r == CNT_ONE) begin
            done_s  = 1'b1;
            close_s = 1'b1;
          end else begin
            win_cnt_s = win_cnt_r - CNT_ONE;
          end
        end else begin
          win_cnt_s = win_cnt_r;
        end
        if (close_s) begin
          win_cnt_s = CNT_ZERO;
          if (HAS_GUARD) begin
            state_s     = GUARD;
            guard_cnt_s = GUARD_LOAD;
          end else begin
            state_s     = IDLE;
            guard_cnt_s = CNT_ZERO;
          end
        end else begin
          state_s = ACTIVE;
        end
      end
      GUARD: begin
        if (bus.tick) begin
          if (guard_cnt_r == CNT_ONE) begin
            state_s     = IDLE;
            guard_cnt_s = CNT_ZERO;
          end else begin
            guard_cnt_s = guard_cnt_r - CNT_ONE;
          end
        end else begin
          guard_cnt_s = guard_cnt_r;
        end
      end
      default: begin
        state_s     = IDLE;
        win_cnt_s   = CNT_ZERO;
        guard_cnt_s = CNT_ZERO;
      end
    endcase
  end

  // State, counters and edge-detect register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      win_cnt_r   <= CNT_ZERO;
      guard_cnt_r <= CNT_ZERO;
      wcount_r    <= {WCNT_W{1'b0}};
      arm_q_r     <= 1'b0;
    end else begin
      state_r     <= state_s;
      win_cnt_r   <= win_cnt_s;
      guard_cnt_r <= guard_cnt_s;
      wcount_r    <= wcount_s;
      arm_q_r     <= bus.arm;
    end
  end

  // Status outputs are registered from the next-state view so they align with the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_enable_r    <= 1'b0;
      guard_active_r <= 1'b0;
      done_r         <= 1'b0;
      aborted_r      <= 1'b0;
    end else begin
      tx_enable_r    <= (state_s == ACTIVE);
      guard_active_r <= (state_s == GUARD);
      done_r         <= done_s;
      aborted_r      <= aborted_s;
    end
  end

  assign bus.tx_enable    = tx_enable_r;
  assign bus.guard_active = guard_active_r;
  assign bus.done         = done_r;
  assign bus.aborted      = aborted_r;
  assign bus.ticks_left   = win_cnt_r;
  assign bus.window_count = wcount_r;

endmodule
